// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SUB_SIGNED_OVF_EN.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             bin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             borrow_o
`ifdef SUB_SIGNED_OVF_EN
   ,
   output logic             ovf_o
`endif
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
`ifdef SUB_SIGNED_OVF_EN
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             ovf_q, ovf_d;
`endif

   // Full-subtractor cell built as two chained half-subtractors.
   logic x, y, d, br_next;
   logic [WIDTH-1:0] res_shift;

   always_comb begin
      x         = a_sh_q[0];
      y         = b_sh_q[0];
      d         = x ^ y ^ br_q;
      br_next   = (~x & y) | (~(x ^ y) & br_q);
      res_shift = {d, res_q[WIDTH-1:1]};
   end

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      cnt_d    = cnt_q;
      br_d     = br_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      diff_d   = diff_q;
      borrow_d = borrow_q;
`ifdef SUB_SIGNED_OVF_EN
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      ovf_d    = ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = RUN;
               a_sh_d  = a_i;
               b_sh_d  = b_i;
               br_d    = bin_i;
               cnt_d   = '0;
               busy_d  = 1'b1;
`ifdef SUB_SIGNED_OVF_EN
               a_msb_d = a_i[WIDTH-1];
               b_msb_d = b_i[WIDTH-1];
`endif
            end
         end
         RUN: begin
            res_d  = res_shift;
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            br_d   = br_next;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d  = IDLE;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               diff_d   = res_shift;
               borrow_d = br_next;
`ifdef SUB_SIGNED_OVF_EN
               ovf_d    = (a_msb_q != b_msb_q) & (d != a_msb_q);
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
         br_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_q    <= res_d;
         cnt_q    <= cnt_d;
         br_q     <= br_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
`ifdef SUB_SIGNED_OVF_EN
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign diff_o   = diff_q;
   assign borrow_o = borrow_q;
`ifdef SUB_SIGNED_OVF_EN
   assign ovf_o    = ovf_q;
`endif

endmodule
